// File: rtl/i2s_tx_stereo_pkg.sv
// Shared types and width helpers for the stereo I2S transmitter.
package i2s_tx_stereo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } i2s_state_t;

  // Occupancy counter width able to hold 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/i2s_tx_stereo_if.sv
// Valid/ready sample-pair write port of the I2S transmitter.
interface i2s_tx_stereo_if #(
  parameter int unsigned D_WIDTH = 16
) ();

  logic               sample_vld;
  logic               sample_rdy;
  logic [D_WIDTH-1:0] sample_l;
  logic [D_WIDTH-1:0] sample_r;

  modport master (output sample_vld, output sample_l, output sample_r, input sample_rdy);
  modport slave  (input sample_vld, input sample_l, input sample_r, output sample_rdy);

endinterface

// File: rtl/i2s_tx_stereo_fifo.sv
// Show-ahead FIFO holding {left,right} pairs; a write into a full FIFO succeeds when a pop happens in the same cycle.
module i2s_tx_stereo_fifo
  import i2s_tx_stereo_pkg::*;
#(
  parameter  int unsigned D_WIDTH = 32,
  parameter  int unsigned D_DEPTH = 4,
  localparam int unsigned CNT_W   = cnt_w(D_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic               rd_en,
  output logic [D_WIDTH-1:0] rd_data_c,
  output logic               full_c,
  output logic               empty_c,
  output logic [CNT_W-1:0]   count
);

  localparam int unsigned AW = $clog2(D_DEPTH);

  logic [D_WIDTH-1:0] mem [D_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               wr_ok_c;
  logic               rd_ok_c;

  assign full_c    = (count == CNT_W'(D_DEPTH));
  assign empty_c   = (count == '0);
  assign wr_ok_c   = wr_en && (!full_c || rd_en);
  assign rd_ok_c   = rd_en && !empty_c;
  assign rd_data_c = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok_c) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(wr_ok_c) - CNT_W'(rd_ok_c);
    end
  end

endmodule

// File: rtl/i2s_tx_stereo.sv
// Stereo I2S transmitter: FIFO-buffered sample pairs serialised into frame-aligned I2S with programmable bclk.
module i2s_tx_stereo
  import i2s_tx_stereo_pkg::*;
#(
  parameter  int unsigned D_WIDTH    = 16,
  parameter  int unsigned SLOT_WIDTH = 32,
  parameter  int unsigned FIFO_DEPTH = 4,
  parameter  int unsigned CDIV_W     = 8,
  localparam int unsigned CNT_W      = cnt_w(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CDIV_W-1:0] bclk_half,
  input  logic              mono,
  i2s_tx_stereo_if.slave    s_if,
  output logic              lr_clk,
  output logic              bclk,
  output logic              dout,
  output logic              underflow,
  output logic [CNT_W-1:0]  fifo_cnt
);

  localparam int unsigned PAIR_W     = 2 * D_WIDTH;
  localparam int unsigned BCNT_W     = $clog2(2 * SLOT_WIDTH);
  localparam int unsigned FRAME_LAST = 2 * SLOT_WIDTH - 1;

  i2s_state_t         state_q, state_d;
  logic [CDIV_W-1:0]  ccnt_q, ccnt_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic [CDIV_W-1:0]  half_q, half_d;
  logic [PAIR_W-1:0]  shadow_q, shadow_d;
  logic               bclk_d, lr_d, dout_d, underflow_d;

  logic               wr_en_c, pop_c, full_c, empty_c, tick_c, wrap_c;
  logic [PAIR_W-1:0]  wr_data_c, rd_data_c;
  logic [CDIV_W-1:0]  half_in_c;
  logic [BCNT_W-1:0]  pos_c;
  logic [D_WIDTH-1:0] chan_c, shifted_c;

  // Mono duplication happens before storage so the entry is self-contained.
  assign wr_en_c         = s_if.sample_vld && s_if.sample_rdy;
  assign wr_data_c       = {s_if.sample_l, (mono ? s_if.sample_l : s_if.sample_r)};
  assign s_if.sample_rdy = !full_c;

  i2s_tx_stereo_fifo #(
    .D_WIDTH (PAIR_W),
    .D_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en_c),
    .wr_data   (wr_data_c),
    .rd_en     (pop_c),
    .rd_data_c (rd_data_c),
    .full_c    (full_c),
    .empty_c   (empty_c),
    .count     (fifo_cnt)
  );

  assign half_in_c = (bclk_half == '0) ? CDIV_W'(1) : bclk_half;
  assign tick_c    = (ccnt_q == half_q - CDIV_W'(1));
  assign wrap_c    = tick_c && bclk && (bcnt_q == BCNT_W'(FRAME_LAST));

  // Next-state, counters and the output values they imply.
  always_comb begin
    state_d     = state_q;
    ccnt_d      = ccnt_q;
    bcnt_d      = bcnt_q;
    bclk_d      = bclk;
    half_d      = half_q;
    shadow_d    = shadow_q;
    pop_c       = 1'b0;
    underflow_d = 1'b0;

    case (state_q)
      IDLE: begin
        ccnt_d = '0;
        bcnt_d = '0;
        bclk_d = 1'b0;
        if (en && !empty_c) begin
          state_d  = RUN;
          pop_c    = 1'b1;
          shadow_d = rd_data_c;
          half_d   = half_in_c;
        end
      end
      RUN, DRAIN: begin
        state_d = en ? RUN : DRAIN;
        if (tick_c) begin
          ccnt_d = '0;
          bclk_d = !bclk;
          if (bclk) bcnt_d = bcnt_q + BCNT_W'(1);
        end else begin
          ccnt_d = ccnt_q + CDIV_W'(1);
        end
        // Frame boundary: continue with the next pair, or stop if run was dropped.
        if (wrap_c) begin
          bcnt_d = '0;
          if (en) begin
            half_d = half_in_c;
            if (!empty_c) begin
              pop_c    = 1'b1;
              shadow_d = rd_data_c;
            end else begin
              shadow_d    = '0;
              underflow_d = 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Slot position carries the one-bit I2S delay: position 0 is a gap bit.
    lr_d      = (bcnt_d >= BCNT_W'(SLOT_WIDTH));
    pos_c     = lr_d ? (bcnt_d - BCNT_W'(SLOT_WIDTH)) : bcnt_d;
    chan_c    = lr_d ? shadow_d[D_WIDTH-1:0] : shadow_d[PAIR_W-1:D_WIDTH];
    shifted_c = chan_c >> (BCNT_W'(D_WIDTH) - pos_c);
    dout_d    = (pos_c != '0) && (pos_c <= BCNT_W'(D_WIDTH)) ? shifted_c[0] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ccnt_q    <= '0;
      bcnt_q    <= '0;
      half_q    <= CDIV_W'(1);
      shadow_q  <= '0;
      bclk      <= 1'b0;
      lr_clk    <= 1'b0;
      dout      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state_q   <= state_d;
      ccnt_q    <= ccnt_d;
      bcnt_q    <= bcnt_d;
      half_q    <= half_d;
      shadow_q  <= shadow_d;
      bclk      <= bclk_d;
      lr_clk    <= lr_d;
      dout      <= dout_d;
      underflow <= underflow_d;
    end
  end

endmodule
